// File: rtl/htif_pkg.sv
// htif_pkg: shared constants for the HTIF host responder.
// FSM state encodings, tohost field positions, well-known words.
package htif_pkg;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_REQ      = 3'd1;
   localparam logic [2:0] ST_WAIT_RSP = 3'd2;
   localparam logic [2:0] ST_WR_FH    = 3'd3;
   localparam logic [2:0] ST_DONE     = 3'd4;

   localparam int DEV_MSB  = 63;
   localparam int CMD_MSB  = 55;
   localparam int EXIT_BIT = 0;

   localparam logic [31:0] EOT_TIMEOUT = 32'hFFFF_FFFF;
   localparam logic [7:0]  DEV_CONSOLE = 8'h01;
   localparam logic [7:0]  CMD_PUTCHAR = 8'h01;

   localparam int unsigned WDOG_W = 32;

   function automatic logic is_putchar(input logic [63:0] w);
      return (w[DEV_MSB -: 8] == DEV_CONSOLE) &&
             (w[CMD_MSB -: 8] == CMD_PUTCHAR);
   endfunction

endpackage

// File: rtl/htif_watchdog.sv
// htif_watchdog: saturating cycle counter with enable and expire pulse.
// Ports: clk_i, rst_i (sync high), en_i (count), expire_o (counter hits LIMIT this edge).
module htif_watchdog #(
   parameter int unsigned W     = 32,
   parameter int unsigned LIMIT = 0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic en_i,
   output logic expire_o
);

   // expire fires on the edge at which the count becomes LIMIT
   localparam logic [W-1:0] LIM_M1 = (LIMIT == 0) ? '0 : W'(LIMIT - 1);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (en_i && (cnt_q != '1)) cnt_d = cnt_q + W'(1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign expire_o = (LIMIT != 0) && en_i && (cnt_q == LIM_M1);

endmodule

// File: rtl/htif_host_responder.sv
// htif_host_responder: host side of the tohost/fromhost mailbox.
// Snoops tohost stores, handles exit, forwards syscalls over svc_req/svc_rsp,
// writes the response to fromhost over wr_*, reports end_of_test_o, counts
// drops, and forces a timeout end via a watchdog.
// Option HTIF_CONSOLE_EN adds console_valid_o/console_data_o for local putchar.
module htif_host_responder
   import htif_pkg::*;
#(
   parameter int unsigned ADDR_W         = 64,
   parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              snoop_valid_i,
   input  logic [ADDR_W-1:0] snoop_addr_i,
   input  logic [63:0]       snoop_wdata_i,
   input  logic [7:0]        snoop_be_i,
   input  logic [ADDR_W-1:0] tohost_addr_i,
   input  logic [ADDR_W-1:0] fromhost_addr_i,
   output logic              svc_req_valid_o,
   input  logic              svc_req_ready_i,
   output logic [63:0]       svc_req_data_o,
   input  logic              svc_rsp_valid_i,
   input  logic [63:0]       svc_rsp_data_i,
   output logic              wr_valid_o,
   input  logic              wr_ready_i,
   output logic [ADDR_W-1:0] wr_addr_o,
   output logic [63:0]       wr_data_o,
   output logic [31:0]       end_of_test_o,
   output logic              busy_o,
   output logic [15:0]       drop_cnt_o
`ifdef HTIF_CONSOLE_EN
   ,
   output logic              console_valid_o,
   output logic [7:0]        console_data_o
`endif
);

   logic [2:0]  state_q, state_d;
   logic [63:0] req_q, req_d;
   logic [63:0] rsp_q, rsp_d;
   logic [31:0] eot_q, eot_d;
   logic [15:0] drop_q, drop_d;

   logic hit, clr_hit, cmd_hit, bad_hit;
   logic busy, fh_en, is_con, exit_req, expire;

`ifdef HTIF_CONSOLE_EN
   logic       con_v_q, con_v_d;
   logic [7:0] con_d_q, con_d_d;
   assign is_con = is_putchar(snoop_wdata_i);
`else
   assign is_con = 1'b0;
`endif

   assign hit = snoop_valid_i && (tohost_addr_i != '0) &&
                (snoop_addr_i == tohost_addr_i);
   // a zero store is the core clearing tohost, never a command
   assign clr_hit = hit && (snoop_wdata_i == '0);
   assign cmd_hit = hit && !clr_hit && (snoop_be_i == 8'hFF);
   assign bad_hit = hit && !clr_hit && (snoop_be_i != 8'hFF);

   assign busy  = (state_q == ST_REQ) || (state_q == ST_WAIT_RSP) ||
                  (state_q == ST_WR_FH);
   assign fh_en = (fromhost_addr_i != '0);

   // exit beats a same-edge timeout
   assign exit_req = (state_q == ST_IDLE) && cmd_hit && !is_con &&
                     snoop_wdata_i[EXIT_BIT];

   htif_watchdog #(
      .W     (WDOG_W),
      .LIMIT (TIMEOUT_CYCLES)
   ) u_wdog (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .en_i     (state_q != ST_DONE),
      .expire_o (expire)
   );

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      rsp_d   = rsp_q;
      eot_d   = eot_q;
      drop_d  = drop_q;
`ifdef HTIF_CONSOLE_EN
      con_v_d = 1'b0;
      con_d_d = con_d_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (cmd_hit) begin
`ifdef HTIF_CONSOLE_EN
               if (is_con) begin
                  con_v_d = 1'b1;
                  con_d_d = snoop_wdata_i[7:0];
                  rsp_d   = {DEV_CONSOLE, CMD_PUTCHAR, 48'h0};
                  state_d = fh_en ? ST_WR_FH : ST_IDLE;
               end else
`endif
               if (snoop_wdata_i[EXIT_BIT]) begin
                  eot_d   = snoop_wdata_i[31:0];
                  state_d = ST_DONE;
               end else begin
                  req_d   = snoop_wdata_i;
                  state_d = ST_REQ;
               end
            end
         end
         ST_REQ: begin
            if (svc_req_ready_i) state_d = ST_WAIT_RSP;
         end
         ST_WAIT_RSP: begin
            if (svc_rsp_valid_i) begin
               rsp_d   = svc_rsp_data_i;
               state_d = fh_en ? ST_WR_FH : ST_IDLE;
            end
         end
         ST_WR_FH: begin
            if (wr_ready_i) state_d = ST_IDLE;
         end
         ST_DONE: ;
         default: state_d = ST_IDLE;
      endcase

      if ((state_q != ST_DONE) && (bad_hit || (cmd_hit && busy)) &&
          (drop_q != 16'hFFFF))
         drop_d = drop_q + 16'd1;

      if (expire && !exit_req) begin
         state_d = ST_DONE;
         eot_d   = EOT_TIMEOUT;
`ifdef HTIF_CONSOLE_EN
         con_v_d = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         req_q   <= '0;
         rsp_q   <= '0;
         eot_q   <= '0;
         drop_q  <= '0;
`ifdef HTIF_CONSOLE_EN
         con_v_q <= 1'b0;
         con_d_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         rsp_q   <= rsp_d;
         eot_q   <= eot_d;
         drop_q  <= drop_d;
`ifdef HTIF_CONSOLE_EN
         con_v_q <= con_v_d;
         con_d_q <= con_d_d;
`endif
      end
   end

   assign svc_req_valid_o = (state_q == ST_REQ);
   assign svc_req_data_o  = req_q;
   assign wr_valid_o      = (state_q == ST_WR_FH);
   assign wr_addr_o       = wr_valid_o ? fromhost_addr_i : '0;
   assign wr_data_o       = wr_valid_o ? rsp_q : '0;
   assign end_of_test_o   = eot_q;
   assign busy_o          = busy;
   assign drop_cnt_o      = drop_q;
`ifdef HTIF_CONSOLE_EN
   assign console_valid_o = con_v_q;
   assign console_data_o  = con_d_q;
`endif

endmodule

// File: tb/tb_htif_host_responder.sv
// tb_htif_host_responder: directed bench with a transaction-level model.
// Model is compared every cycle; literal checks pin key scenarios.
module tb_htif_host_responder;

   localparam int unsigned TMO = 100;
   localparam logic [63:0] TOHOST   = 64'h4000_0000;
   localparam logic [63:0] FROMHOST = 64'h4000_0040;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        snoop_valid = 1'b0;
   logic [63:0] snoop_addr = '0;
   logic [63:0] snoop_wdata = '0;
   logic [7:0]  snoop_be = '0;
   logic [63:0] tohost = TOHOST;
   logic [63:0] fromhost = FROMHOST;
   logic        req_ready = 1'b0;
   logic        rsp_valid = 1'b0;
   logic [63:0] rsp_data = '0;
   logic        wr_ready = 1'b0;

   logic        req_valid_o, wr_valid_o, busy_o;
   logic [63:0] req_data_o, wr_addr_o, wr_data_o;
   logic [31:0] eot_o;
   logic [15:0] drop_o;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   htif_host_responder #(
      .ADDR_W         (64),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .snoop_valid_i   (snoop_valid),
      .snoop_addr_i    (snoop_addr),
      .snoop_wdata_i   (snoop_wdata),
      .snoop_be_i      (snoop_be),
      .tohost_addr_i   (tohost),
      .fromhost_addr_i (fromhost),
      .svc_req_valid_o (req_valid_o),
      .svc_req_ready_i (req_ready),
      .svc_req_data_o  (req_data_o),
      .svc_rsp_valid_i (rsp_valid),
      .svc_rsp_data_i  (rsp_data),
      .wr_valid_o      (wr_valid_o),
      .wr_ready_i      (wr_ready),
      .wr_addr_o       (wr_addr_o),
      .wr_data_o       (wr_data_o),
      .end_of_test_o   (eot_o),
      .busy_o          (busy_o),
      .drop_cnt_o      (drop_o)
   );

   task automatic chk(input string name, input logic [63:0] got,
                      input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   // ---------------- transaction-level model ----------------
   typedef enum int {M_IDLE, M_REQ, M_WAIT, M_WB} mph_t;
   mph_t        m_ph = M_IDLE;
   bit          m_fin = 1'b0;
   logic [31:0] m_eot = '0;
   int unsigned m_drop = 0;
   longint unsigned m_cyc = 0;
   logic [63:0] m_req = '0;
   logic [63:0] m_rsp = '0;
   bit          model_on = 1'b0;
   int          wr_count = 0;
   logic        wv_s = 1'b0;

   always @(posedge clk) begin : model
      bit   hit;
      bit   exit_now;
      mph_t nxt;
      if (rst) begin
         m_ph = M_IDLE; m_fin = 1'b0; m_eot = '0; m_drop = 0;
         m_cyc = 0; m_req = '0; m_rsp = '0; wr_count = 0;
         model_on = 1'b1;
      end else begin
         if (wv_s && wr_ready) wr_count++;
         if (!m_fin) begin
            hit = snoop_valid && (tohost != 0) && (snoop_addr == tohost);
            exit_now = 1'b0;
            nxt = m_ph;
            if (m_ph == M_REQ && req_ready) nxt = M_WAIT;
            if (m_ph == M_WAIT && rsp_valid) begin
               m_rsp = rsp_data;
               nxt = (fromhost != 0) ? M_WB : M_IDLE;
            end
            if (m_ph == M_WB && wr_ready) nxt = M_IDLE;
            if (hit && snoop_wdata != 0) begin
               if (snoop_be != 8'hFF || m_ph != M_IDLE) begin
                  if (m_drop < 65535) m_drop++;
               end else if (snoop_wdata[0]) begin
                  exit_now = 1'b1;
               end else begin
                  m_req = snoop_wdata;
                  nxt = M_REQ;
               end
            end
            if (m_cyc < 64'hFFFF_FFFF) m_cyc++;
            if (exit_now) begin
               m_fin = 1'b1; m_eot = snoop_wdata[31:0]; nxt = M_IDLE;
            end else if (TMO != 0 && m_cyc == TMO) begin
               m_fin = 1'b1; m_eot = 32'hFFFF_FFFF; nxt = M_IDLE;
            end
            m_ph = nxt;
         end
      end
   end

   always @(negedge clk) begin
      wv_s = wr_valid_o;
      if (model_on) begin
         chk("req_valid", req_valid_o, m_ph == M_REQ);
         chk("req_data", req_data_o, m_req);
         chk("wr_valid", wr_valid_o, m_ph == M_WB);
         chk("wr_addr", wr_addr_o, (m_ph == M_WB) ? fromhost : 64'h0);
         chk("wr_data", wr_data_o, (m_ph == M_WB) ? m_rsp : 64'h0);
         chk("eot", eot_o, m_eot);
         chk("busy", busy_o, m_ph != M_IDLE);
         chk("drop", drop_o, m_drop[15:0]);
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      snoop_valid = 1'b0; req_ready = 1'b0;
      rsp_valid = 1'b0; wr_ready = 1'b0;
      tohost = TOHOST; fromhost = FROMHOST;
      repeat (2) step();
      chk("rst_eot", eot_o, 0);
      chk("rst_req_valid", req_valid_o, 0);
      chk("rst_wr_valid", wr_valid_o, 0);
      chk("rst_drop", drop_o, 0);
      rst = 1'b0;
   endtask

   task automatic store(input logic [63:0] d, input logic [7:0] be);
      snoop_valid = 1'b1;
      snoop_addr  = tohost;
      snoop_wdata = d;
      snoop_be    = be;
      step();
      snoop_valid = 1'b0;
   endtask

   initial begin
      // exit, then later store ignored
      do_reset();
      store(64'h1, 8'hFF);
      chk("t1_eot", eot_o, 32'h1);
      chk("t1_busy", busy_o, 0);
      store(64'h3, 8'hFF);
      chk("t1_eot_keep", eot_o, 32'h1);
      chk("t1_drop", drop_o, 0);

      // syscall round trip with overlap drop
      do_reset();
      store(64'h8000_1230, 8'hFF);
      for (int i = 0; i < 3; i++) begin
         chk("t2_req_valid_hold", req_valid_o, 1);
         chk("t2_req_data_hold", req_data_o, 64'h8000_1230);
         step();
      end
      chk("t2_req_valid_last", req_valid_o, 1);
      req_ready = 1'b1;
      step();
      req_ready = 1'b0;
      chk("t2_req_valid_off", req_valid_o, 0);
      chk("t2_busy_wait", busy_o, 1);
      store(64'h8000_2000, 8'hFF);
      chk("t3_drop", drop_o, 1);
      chk("t3_req_data", req_data_o, 64'h8000_1230);
      rsp_valid = 1'b1; rsp_data = 64'h1;
      step();
      rsp_valid = 1'b0;
      chk("t2_wr_valid", wr_valid_o, 1);
      chk("t2_wr_addr", wr_addr_o, 64'h4000_0040);
      chk("t2_wr_data", wr_data_o, 64'h1);
      step();
      chk("t2_wr_valid_hold", wr_valid_o, 1);
      wr_ready = 1'b1;
      step();
      wr_ready = 1'b0;
      chk("t2_wr_done", wr_valid_o, 0);
      chk("t2_busy_idle", busy_o, 0);
      chk("t2_wr_count", wr_count, 1);

      // clears, partial writes, stray response, no mailbox
      do_reset();
      store(64'h0, 8'hFF);
      chk("t5_clear_busy", busy_o, 0);
      chk("t5_clear_drop", drop_o, 0);
      store(64'h8000_0000, 8'h0F);
      chk("t5_partial_drop", drop_o, 1);
      chk("t5_partial_noreq", req_valid_o, 0);
      rsp_valid = 1'b1; rsp_data = 64'hDEAD;
      step();
      rsp_valid = 1'b0;
      chk("t5_stray_rsp", wr_valid_o, 0);
      tohost = 64'h0;
      store(64'h8000_0000, 8'hFF);
      chk("t5_nombox_busy", busy_o, 0);
      chk("t5_nombox_drop", drop_o, 1);
      tohost = TOHOST;

      // minimum latency, then reset during WR_FH
      do_reset();
      req_ready = 1'b1;
      store(64'h8000_3000, 8'hFF);
      chk("t6_req_n1", req_valid_o, 1);
      step();
      req_ready = 1'b0;
      rsp_valid = 1'b1; rsp_data = 64'h55;
      step();
      rsp_valid = 1'b0;
      chk("t6_wr_n3", wr_valid_o, 1);
      chk("t6_wr_data", wr_data_o, 64'h55);
      step();
      chk("t6_wr_hold", wr_valid_o, 1);
      rst = 1'b1;
      step();
      chk("t6_rst_wr", wr_valid_o, 0);
      chk("t6_rst_busy", busy_o, 0);
      chk("t6_rst_req_data", req_data_o, 0);
      rst = 1'b0;
      step();
      chk("t6_wr_count", wr_count, 0);

      // idle timeout after exactly TMO cycles
      do_reset();
      repeat (TMO - 1) step();
      chk("t4_eot_before", eot_o, 0);
      step();
      chk("t4_eot_timeout", eot_o, 32'hFFFF_FFFF);

      // timeout while requesting drops the valid
      do_reset();
      store(64'h8000_4000, 8'hFF);
      repeat (TMO - 2) step();
      chk("t4b_req_before", req_valid_o, 1);
      step();
      chk("t4b_req_dropped", req_valid_o, 0);
      chk("t4b_eot", eot_o, 32'hFFFF_FFFF);

      // exit on the timeout edge wins
      do_reset();
      repeat (TMO - 1) step();
      store(64'h5, 8'hFF);
      chk("t4c_exit_wins", eot_o, 32'h5);

      step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/htif_host_responder.md
Name: htif_host_responder

Overview:
- Host-side end of the tohost/fromhost (HTIF) mailbox protocol used by CVA6 test programs.
- Snoops committed stores to `tohost` and decodes each one as either an exit request or a syscall.
- Syscalls are forwarded to an external service port over a valid/ready handshake. The service response is written back to `fromhost` through a write-master port, so the core's polling loop completes.
- Also provides end-of-test reporting and a timeout watchdog.

Parameters:
- ADDR_W, 64, width of snooped and written addresses.
- TIMEOUT_CYCLES, 2000000, cycle count after which a timeout end-of-test is forced; 0 disables the watchdog.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- snoop_valid_i  in  1  committed store observed this cycle
- snoop_addr_i  in  ADDR_W  physical store address
- snoop_wdata_i  in  64  store data
- snoop_be_i  in  8  store byte enables
- tohost_addr_i  in  ADDR_W  tohost address; 0 means no mailbox
- fromhost_addr_i  in  ADDR_W  fromhost address
- svc_req_valid_o  out  1  syscall request valid
- svc_req_ready_i  in  1  service accepts request
- svc_req_data_o  out  64  tohost word forwarded
- svc_rsp_valid_i  in  1  service response (single-cycle pulse)
- svc_rsp_data_i  in  64  response payload
- wr_valid_o  out  1  fromhost write request
- wr_ready_i  in  1  write accepted
- wr_addr_o  out  ADDR_W  write address (= fromhost_addr_i)
- wr_data_o  out  64  write data
- end_of_test_o  out  32  0 while running; exit word or 0xFFFF_FFFF on timeout
- busy_o  out  1  syscall in flight
- drop_cnt_o  out  16  tohost stores ignored because busy or malformed

Behaviour:
- **Reset:** all outputs 0; state IDLE; cycle counter 0.
- **Mailbox hit:** snoop_valid_i && tohost_addr_i != 0 && snoop_addr_i == tohost_addr_i.
- **Hit with wdata == 0:** the core is clearing tohost. Ignored; not counted as a drop.
- **Hit with snoop_be_i != 8'hFF:** malformed; drop_cnt_o += 1 (saturating at 0xFFFF).
- **State machine** (IDLE, REQ, WAIT_RSP, WR_FH, DONE):
  - **IDLE, hit with wdata[0] == 1:** end_of_test_o <= wdata[31:0] on the next edge; go to DONE.
  - **IDLE, hit with wdata[0] == 0:** latch wdata into svc_req_data_o; go to REQ.
  - **REQ:** svc_req_valid_o = 1. Data is held stable until svc_req_ready_i. Then go to WAIT_RSP.
  - **WAIT_RSP:** on svc_rsp_valid_i, latch svc_rsp_data_i and go to WR_FH.
  - **WR_FH:** wr_valid_o = 1; wr_addr_o = fromhost_addr_i; wr_data_o = latched response. On wr_ready_i, return to IDLE.
  - **Skipping the write-back:** if fromhost_addr_i == 0, WR_FH is skipped and WAIT_RSP returns directly to IDLE.
  - **DONE:** terminal; stays until reset. Further snoops are ignored and not counted.
- **busy_o** = 1 in REQ, WAIT_RSP and WR_FH.
- **Hit while busy:** drop_cnt_o += 1. This applies to exit requests too: an exit requires IDLE.
- **Minimum round-trip latency:** hit in cycle N → request valid in N+1 → (ready same cycle, response in N+2) → wr_valid_o in N+3.
- **svc_rsp_valid_i outside WAIT_RSP:** ignored.
- **Watchdog:** cycle counter increments every cycle outside DONE. It saturates rather than wrapping.
- **Timeout:** when the counter reaches TIMEOUT_CYCLES (nonzero), end_of_test_o <= 32'hFFFF_FFFF and state goes to DONE, regardless of the in-flight handshake. Outstanding valids drop the same edge.
- **Simultaneous exit hit and timeout:** the exit hit wins.
- **Reset asserted mid-handshake:** aborts immediately. All valids go to 0 the next cycle; no fromhost write is issued.

Optional Feature:
- Macro: HTIF_CONSOLE_EN.
- **Defined:** adds outputs console_valid_o (1) and console_data_o (8).
- **Console command:** a hit in IDLE with wdata[63:56] == 8'h01 (device) and wdata[55:48] == 8'h01 (cmd putchar) is handled locally:
  - Pulse console_valid_o for 1 cycle with wdata[7:0].
  - Then WR_FH with data {8'h01, 8'h01, 48'h0}.
  - No service request is made.
- **Undefined:** these ports are absent and all nonzero, non-exit words go to the service port.

Decomposition:
- **htif_pkg:** state enum; field positions (DEV_MSB = 63, CMD_MSB = 55, EXIT_BIT = 0); constants EOT_TIMEOUT = 32'hFFFF_FFFF, DEV_CONSOLE = 8'h01, CMD_PUTCHAR = 8'h01.
- **Sub-module htif_watchdog:** saturating counter with enable and an expire pulse, instantiated once.

Test Plan:
1. **Exit:** tohost = 0x4000_0000, store wdata 0x1 → end_of_test_o = 0x1 one cycle later, DONE. A later store of 0x3 is ignored; drop_cnt_o stays 0.
2. **Syscall round trip:** store 0x8000_1230, ready held 0 for 3 cycles, then 1. Response 0x1 → svc_req_data_o = 0x8000_1230 stable throughout; then exactly one write of 0x1 to fromhost 0x4000_0040 before returning to IDLE.
3. **Overlap drop:** second tohost store 0x8000_2000 during WAIT_RSP → drop_cnt_o = 1; first syscall completes normally.
4. **Timeout:** TIMEOUT_CYCLES = 100, no stores → end_of_test_o = 0xFFFF_FFFF after 100 cycles. Also verify timeout during REQ drops svc_req_valid_o.
5. **Clear and partial writes:** store 0x0 → no action. Store 0x8000_0000 with be 8'h0F → drop_cnt_o += 1, no request.
6. **Reset during WR_FH (wr_ready_i held 0):** wr_valid_o = 0 next cycle; all outputs return to 0.
